// File: rtl/vx_axi_mem_bridge.sv
// Bridges the core memory request/response port onto a single-beat AXI4 master.
// Registered AW/W/AR holding slots decouple the core from AXI channel backpressure.
module vx_axi_mem_bridge #(
   parameter int unsigned DATA_WIDTH     = 512,
   parameter int unsigned MEM_ADDR_WIDTH = 26,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned TAG_WIDTH      = 8,
   parameter int unsigned MAX_RD         = 16,
   parameter int unsigned MAX_WR         = 16,
   parameter int unsigned WRITE_RSP      = 0
) (
   input  logic                        clk,
   input  logic                        reset,

   input  logic                        mem_req_valid,
   input  logic                        mem_req_rw,
   input  logic [DATA_WIDTH/8-1:0]     mem_req_byteen,
   input  logic [MEM_ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic [DATA_WIDTH-1:0]       mem_req_data,
   input  logic [TAG_WIDTH-1:0]        mem_req_tag,
   output logic                        mem_req_ready,

   output logic                        mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]       mem_rsp_data,
   output logic [TAG_WIDTH-1:0]        mem_rsp_tag,
   input  logic                        mem_rsp_ready,

   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [TAG_WIDTH-1:0]        m_axi_awid,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   output logic                        m_axi_awlock,
   output logic [3:0]                  m_axi_awcache,
   output logic [2:0]                  m_axi_awprot,
   output logic [3:0]                  m_axi_awqos,

   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [DATA_WIDTH-1:0]       m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
   output logic                        m_axi_wlast,

   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [TAG_WIDTH-1:0]        m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,

   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [TAG_WIDTH-1:0]        m_axi_arid,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic                        m_axi_arlock,
   output logic [3:0]                  m_axi_arcache,
   output logic [2:0]                  m_axi_arprot,
   output logic [3:0]                  m_axi_arqos,

   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
   input  logic                        m_axi_rlast,
   input  logic [TAG_WIDTH-1:0]        m_axi_rid,
   input  logic [1:0]                  m_axi_rresp,

   output logic                        busy,
   output logic                        axi_err
);

   localparam int unsigned STRB_W       = DATA_WIDTH / 8;
   localparam int unsigned OFS_W        = $clog2(STRB_W);
   localparam int unsigned BADDR_W      = MEM_ADDR_WIDTH + OFS_W;
   localparam int unsigned RD_CNT_W     = $clog2(MAX_RD + 1);
   localparam int unsigned WR_CNT_W     = $clog2(MAX_WR + 1);
   localparam bit          WRITE_RSP_EN = (WRITE_RSP != 0);

   logic                      aw_v_q, aw_v_d;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [TAG_WIDTH-1:0]      awid_q, awid_d;
   logic                      w_v_q, w_v_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]         wstrb_q, wstrb_d;
   logic                      ar_v_q, ar_v_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [TAG_WIDTH-1:0]      arid_q, arid_d;
   logic [RD_CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
   logic [WR_CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic                      axi_err_q, axi_err_d;

   logic [BADDR_W-1:0]        req_baddr;
   logic [AXI_ADDR_WIDTH-1:0] req_axi_addr;
   logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
   logic rd_ready, wr_ready, rd_fire, wr_fire, rd_done, wr_done, fwd_b;

   // Line address to byte address, fitted to the AXI address width
   assign req_baddr    = {mem_req_addr, OFS_W'(0)};
   assign req_axi_addr = AXI_ADDR_WIDTH'(req_baddr);

   assign aw_hs = aw_v_q && m_axi_awready;
   assign w_hs  = w_v_q && m_axi_wready;
   assign ar_hs = ar_v_q && m_axi_arready;
   assign r_hs  = m_axi_rvalid && m_axi_rready;
   assign b_hs  = m_axi_bvalid && m_axi_bready;

   // A slot may be refilled in the cycle it drains; the counter caps outstanding traffic
   assign rd_ready = (!ar_v_q || m_axi_arready) && (rd_cnt_q < RD_CNT_W'(MAX_RD));
   assign wr_ready = (!aw_v_q || m_axi_awready) && (!w_v_q || m_axi_wready)
                     && (wr_cnt_q < WR_CNT_W'(MAX_WR));

   assign mem_req_ready = reset && (mem_req_rw ? wr_ready : rd_ready);
   assign rd_fire       = mem_req_valid && mem_req_ready && !mem_req_rw;
   assign wr_fire       = mem_req_valid && mem_req_ready && mem_req_rw;

   // A read completes on its last beat; counts never go below zero
   assign rd_done = r_hs && m_axi_rlast && (rd_cnt_q != '0);
   assign wr_done = b_hs && (wr_cnt_q != '0);

   // R has fixed priority; B is only forwarded when write completions are enabled
   assign fwd_b         = WRITE_RSP_EN && m_axi_bvalid && !m_axi_rvalid;
   assign mem_rsp_valid = m_axi_rvalid || fwd_b;
   assign mem_rsp_data  = fwd_b ? '0 : m_axi_rdata;
   assign mem_rsp_tag   = fwd_b ? m_axi_bid : m_axi_rid;
   assign m_axi_rready  = reset && mem_rsp_ready && !fwd_b;
   assign m_axi_bready  = reset && (WRITE_RSP_EN ? (fwd_b && mem_rsp_ready) : 1'b1);

   always_comb begin
      aw_v_d    = aw_v_q;
      awaddr_d  = awaddr_q;
      awid_d    = awid_q;
      w_v_d     = w_v_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      ar_v_d    = ar_v_q;
      araddr_d  = araddr_q;
      arid_d    = arid_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      axi_err_d = axi_err_q;

      if (aw_hs) aw_v_d = 1'b0;
      if (w_hs)  w_v_d  = 1'b0;
      if (ar_hs) ar_v_d = 1'b0;

      // Write acceptance loads AW and W together
      if (wr_fire) begin
         aw_v_d   = 1'b1;
         awaddr_d = req_axi_addr;
         awid_d   = mem_req_tag;
         w_v_d    = 1'b1;
         wdata_d  = mem_req_data;
         wstrb_d  = mem_req_byteen;
      end

      if (rd_fire) begin
         ar_v_d   = 1'b1;
         araddr_d = req_axi_addr;
         arid_d   = mem_req_tag;
      end

      case ({rd_fire, rd_done})
         2'b10:   rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
         2'b01:   rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
         default: ;
      endcase

      case ({wr_fire, wr_done})
         2'b10:   wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
         2'b01:   wr_cnt_d = wr_cnt_q - WR_CNT_W'(1);
         default: ;
      endcase

      if ((r_hs && (m_axi_rresp != 2'b00)) || (b_hs && (m_axi_bresp != 2'b00)))
         axi_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aw_v_q    <= 1'b0;
         awaddr_q  <= '0;
         awid_q    <= '0;
         w_v_q     <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         ar_v_q    <= 1'b0;
         araddr_q  <= '0;
         arid_q    <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         axi_err_q <= 1'b0;
      end else begin
         aw_v_q    <= aw_v_d;
         awaddr_q  <= awaddr_d;
         awid_q    <= awid_d;
         w_v_q     <= w_v_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         ar_v_q    <= ar_v_d;
         araddr_q  <= araddr_d;
         arid_q    <= arid_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         axi_err_q <= axi_err_d;
      end
   end

   assign m_axi_awvalid = aw_v_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awid    = awid_q;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = 3'(OFS_W);
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awqos   = 4'b0000;

   assign m_axi_wvalid  = w_v_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = 1'b1;

   assign m_axi_arvalid = ar_v_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arid    = arid_q;
   assign m_axi_arlen   = 8'd0;
   assign m_axi_arsize  = 3'(OFS_W);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;

   assign busy    = aw_v_q || w_v_q || ar_v_q || (rd_cnt_q != '0) || (wr_cnt_q != '0);
   assign axi_err = axi_err_q;

endmodule

// File: tb/tb_vx_axi_mem_bridge.sv
// Scoreboard bench for vx_axi_mem_bridge: expected core responses are queued at
// request time and popped by a response monitor; per-scenario tasks check AXI side.
module tb_vx_axi_mem_bridge;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          mem_req_valid, mem_req_rw, mem_req_ready;
   logic [63:0]   mem_req_byteen;
   logic [25:0]   mem_req_addr;
   logic [511:0]  mem_req_data;
   logic [7:0]    mem_req_tag;
   logic          mem_rsp_valid, mem_rsp_ready;
   logic [511:0]  mem_rsp_data;
   logic [7:0]    mem_rsp_tag;

   logic          m_axi_awvalid, m_axi_awready, m_axi_awlock;
   logic [31:0]   m_axi_awaddr;
   logic [7:0]    m_axi_awid, m_axi_awlen;
   logic [2:0]    m_axi_awsize, m_axi_awprot;
   logic [1:0]    m_axi_awburst;
   logic [3:0]    m_axi_awcache, m_axi_awqos;
   logic          m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [511:0]  m_axi_wdata;
   logic [63:0]   m_axi_wstrb;
   logic          m_axi_bvalid, m_axi_bready;
   logic [7:0]    m_axi_bid;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_arvalid, m_axi_arready, m_axi_arlock;
   logic [31:0]   m_axi_araddr;
   logic [7:0]    m_axi_arid, m_axi_arlen;
   logic [2:0]    m_axi_arsize, m_axi_arprot;
   logic [1:0]    m_axi_arburst;
   logic [3:0]    m_axi_arcache, m_axi_arqos;
   logic          m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [511:0]  m_axi_rdata;
   logic [7:0]    m_axi_rid;
   logic [1:0]    m_axi_rresp;
   logic          busy, axi_err;

   vx_axi_mem_bridge #(
      .DATA_WIDTH(512), .MEM_ADDR_WIDTH(26), .AXI_ADDR_WIDTH(32), .TAG_WIDTH(8),
      .MAX_RD(2), .MAX_WR(2), .WRITE_RSP(1)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .mem_rsp_ready(mem_rsp_ready),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
      .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
      .busy(busy), .axi_err(axi_err)
   );

   typedef struct packed {
      logic [7:0]   tag;
      logic [511:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic expect_rsp(input logic [7:0] tag, input logic [511:0] data);
      exp_t e;
      e.tag  = tag;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Response monitor: a handshake seen mid-cycle completes on the next rising edge
   always @(negedge clk) begin
      if (reset === 1'b1 && mem_rsp_valid === 1'b1 && mem_rsp_ready === 1'b1) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL rsp_unexpected: got tag %h, required no response", mem_rsp_tag);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (mem_rsp_tag !== e.tag || mem_rsp_data !== e.data)
               $display("FAIL rsp_match: got tag %h data[63:0] %h, required tag %h data[63:0] %h",
                        mem_rsp_tag, mem_rsp_data[63:0], e.tag, e.data[63:0]);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and holds it until accepted (bounded)
   task automatic do_req(input logic rw, input logic [25:0] addr, input logic [7:0] tag,
                         input logic [511:0] data);
      int n = 0;
      mem_req_valid = 1'b1;
      mem_req_rw    = rw;
      mem_req_addr  = addr;
      mem_req_tag   = tag;
      mem_req_data  = data;
      #1;
      while (mem_req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n_total++;
      if (mem_req_ready !== 1'b1)
         $display("FAIL req_accept: tag %h ready %b, required 1", tag, mem_req_ready);
      else
         n_pass++;
      tick();
      mem_req_valid = 1'b0;
   endtask

   task automatic send_r(input logic [7:0] tag, input logic [511:0] data, input logic [1:0] resp);
      int n = 0;
      m_axi_rvalid = 1'b1;
      m_axi_rid    = tag;
      m_axi_rdata  = data;
      m_axi_rresp  = resp;
      m_axi_rlast  = 1'b1;
      #1;
      while (m_axi_rready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n_total++;
      if (m_axi_rready !== 1'b1) $display("FAIL r_accept: rready %b, required 1", m_axi_rready);
      else n_pass++;
      tick();
      m_axi_rvalid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] tag, input logic [1:0] resp);
      int n = 0;
      m_axi_bvalid = 1'b1;
      m_axi_bid    = tag;
      m_axi_bresp  = resp;
      #1;
      while (m_axi_bready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n_total++;
      if (m_axi_bready !== 1'b1) $display("FAIL b_accept: bready %b, required 1", m_axi_bready);
      else n_pass++;
      tick();
      m_axi_bvalid = 1'b0;
   endtask

   task automatic test_reset();
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      #1;
      n_total += 4;
      if (mem_req_ready !== 1'b0 || m_axi_rready !== 1'b0 || m_axi_bready !== 1'b0)
         $display("FAIL reset_readies: got %b%b%b, required 000", mem_req_ready, m_axi_rready, m_axi_bready);
      else n_pass++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b000)
         $display("FAIL reset_valids: got %b, required 000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid});
      else n_pass++;
      if (busy !== 1'b0 || axi_err !== 1'b0)
         $display("FAIL reset_flags: busy %b err %b, required 0 0", busy, axi_err);
      else n_pass++;
      if (m_axi_araddr !== 32'h0 || m_axi_awaddr !== 32'h0 || m_axi_wdata !== 512'h0 || m_axi_arid !== 8'h0)
         $display("FAIL reset_regs: araddr %h awaddr %h, required 0", m_axi_araddr, m_axi_awaddr);
      else n_pass++;
      mem_req_valid = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_read();
      logic [511:0] d = {8{64'hDEAD_BEEF_0000_0003}};
      mem_req_rw = 1'b0;
      #1;
      n_total++;
      if (mem_req_ready !== 1'b1) $display("FAIL read_ready_idle: got %b, required 1", mem_req_ready);
      else n_pass++;
      do_req(1'b0, 26'h10, 8'h03, '0);
      expect_rsp(8'h03, d);
      n_total += 4;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h400)
         $display("FAIL read_ar: valid %b addr %h, required 1 00000400", m_axi_arvalid, m_axi_araddr);
      else n_pass++;
      if (m_axi_arid !== 8'h03) $display("FAIL read_arid: got %h, required 03", m_axi_arid);
      else n_pass++;
      if ({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}
          !== {8'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000})
         $display("FAIL read_ar_attr: len %h size %h burst %h cache %h, required 00 6 1 3",
                  m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache);
      else n_pass++;
      if (busy !== 1'b1) $display("FAIL read_busy: got %b, required 1", busy);
      else n_pass++;
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      n_total++;
      if (m_axi_arvalid !== 1'b0) $display("FAIL read_ar_drain: got %b, required 0", m_axi_arvalid);
      else n_pass++;
      send_r(8'h03, d, 2'b00);
      n_total++;
      if (busy !== 1'b0) $display("FAIL read_busy_done: got %b, required 0", busy);
      else n_pass++;
   endtask

   task automatic test_max_rd();
      logic [511:0] d4 = {8{64'h4444_0000_AAAA_0004}};
      logic [511:0] d5 = {8{64'h5555_0000_BBBB_0005}};
      logic [511:0] d6 = {8{64'h6666_0000_CCCC_0006}};
      m_axi_arready = 1'b1;
      do_req(1'b0, 26'h1, 8'h04, '0);
      expect_rsp(8'h04, d4);
      do_req(1'b0, 26'h2, 8'h05, '0);
      expect_rsp(8'h05, d5);
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_tag   = 8'h06;
      mem_req_addr  = 26'h3;
      #1;
      n_total++;
      if (mem_req_ready !== 1'b0) $display("FAIL maxrd_stall0: got %b, required 0", mem_req_ready);
      else n_pass++;
      tick();
      n_total++;
      if (mem_req_ready !== 1'b0) $display("FAIL maxrd_stall1: got %b, required 0", mem_req_ready);
      else n_pass++;
      m_axi_rvalid = 1'b1;
      m_axi_rid    = 8'h04;
      m_axi_rdata  = d4;
      m_axi_rresp  = 2'b00;
      m_axi_rlast  = 1'b1;
      #1;
      n_total++;
      if (mem_req_ready !== 1'b0 || m_axi_rready !== 1'b1)
         $display("FAIL maxrd_during_r: ready %b rready %b, required 0 1", mem_req_ready, m_axi_rready);
      else n_pass++;
      tick();
      m_axi_rvalid = 1'b0;
      n_total++;
      if (mem_req_ready !== 1'b1) $display("FAIL maxrd_reopen: got %b, required 1", mem_req_ready);
      else n_pass++;
      expect_rsp(8'h06, d6);
      tick();
      mem_req_valid = 1'b0;
      send_r(8'h05, d5, 2'b00);
      send_r(8'h06, d6, 2'b00);
      m_axi_arready = 1'b0;
      n_total++;
      if (busy !== 1'b0) $display("FAIL maxrd_busy_done: got %b, required 0", busy);
      else n_pass++;
   endtask

   task automatic test_write();
      logic [511:0] wd1 = {8{64'h0123_4567_89AB_CDEF}};
      logic [511:0] wd2 = {8{64'hFEDC_BA98_7654_3210}};
      int wv_cycles = 0;
      mem_req_byteen = 64'h00FF_00FF_00FF_00FF;
      m_axi_awready  = 1'b1;
      m_axi_wready   = 1'b0;
      do_req(1'b1, 26'h2, 8'h07, wd1);
      expect_rsp(8'h07, '0);
      n_total += 3;
      if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h80 || m_axi_awid !== 8'h07)
         $display("FAIL write_aw: valid %b addr %h id %h, required 1 00000080 07",
                  m_axi_awvalid, m_axi_awaddr, m_axi_awid);
      else n_pass++;
      if (m_axi_wdata !== wd1 || m_axi_wstrb !== 64'h00FF_00FF_00FF_00FF || m_axi_wlast !== 1'b1)
         $display("FAIL write_w: strb %h last %b, required 00ff00ff00ff00ff 1", m_axi_wstrb, m_axi_wlast);
      else n_pass++;
      if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}
          !== {8'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000})
         $display("FAIL write_aw_attr: len %h size %h burst %h, required 00 6 1",
                  m_axi_awlen, m_axi_awsize, m_axi_awburst);
      else n_pass++;
      if (m_axi_wvalid === 1'b1) wv_cycles++;
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_tag   = 8'h08;
      mem_req_addr  = 26'h3;
      mem_req_data  = wd2;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1 || 1'b1) ;
         #1;
         n_total++;
         if (mem_req_ready !== 1'b0) $display("FAIL write_stall: cycle %0d got %b, required 0", k, mem_req_ready);
         else n_pass++;
         @(posedge clk);
         #1;
         if (m_axi_wvalid === 1'b1) wv_cycles++;
         if (k == 1) begin
            n_total++;
            if (m_axi_awvalid !== 1'b0) $display("FAIL write_aw_drain: got %b, required 0", m_axi_awvalid);
            else n_pass++;
         end
      end
      m_axi_wready = 1'b1;
      #1;
      n_total++;
      if (mem_req_ready !== 1'b1) $display("FAIL write_reopen: got %b, required 1", mem_req_ready);
      else n_pass++;
      expect_rsp(8'h08, '0);
      tick();
      mem_req_valid = 1'b0;
      n_total += 2;
      if (wv_cycles != 6) $display("FAIL write_wvalid_len: got %0d cycles, required 6", wv_cycles);
      else n_pass++;
      if (m_axi_awid !== 8'h08 || m_axi_wvalid !== 1'b1 || m_axi_wdata !== wd2)
         $display("FAIL write_second: awid %h wvalid %b, required 08 1", m_axi_awid, m_axi_wvalid);
      else n_pass++;
      tick();
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      n_total++;
      if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || busy !== 1'b1)
         $display("FAIL write_drained: aw %b w %b busy %b, required 0 0 1", m_axi_awvalid, m_axi_wvalid, busy);
      else n_pass++;
      send_b(8'h07, 2'b00);
      send_b(8'h08, 2'b00);
      mem_req_byteen = '1;
      n_total++;
      if (busy !== 1'b0) $display("FAIL write_busy_done: got %b, required 0", busy);
      else n_pass++;
   endtask

   task automatic test_rb_priority();
      logic [511:0] rd = {8{64'h9999_1234_5678_0009}};
      m_axi_arready = 1'b1;
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      do_req(1'b0, 26'h9, 8'h09, '0);
      expect_rsp(8'h09, rd);
      do_req(1'b1, 26'hA, 8'h0A, {16{32'h0A0A_0A0A}});
      expect_rsp(8'h0A, '0);
      tick();
      m_axi_arready = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_rvalid  = 1'b1;
      m_axi_rid     = 8'h09;
      m_axi_rdata   = rd;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b1;
      m_axi_bvalid  = 1'b1;
      m_axi_bid     = 8'h0A;
      m_axi_bresp   = 2'b00;
      #1;
      n_total++;
      if (mem_rsp_tag !== 8'h09 || m_axi_rready !== 1'b1 || m_axi_bready !== 1'b0)
         $display("FAIL prio_r_first: tag %h rready %b bready %b, required 09 1 0",
                  mem_rsp_tag, m_axi_rready, m_axi_bready);
      else n_pass++;
      tick();
      m_axi_rvalid = 1'b0;
      #1;
      n_total++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== 8'h0A || mem_rsp_data !== 512'h0
          || m_axi_bready !== 1'b1 || m_axi_rready !== 1'b0)
         $display("FAIL prio_b_next: valid %b tag %h bready %b rready %b, required 1 0a 1 0",
                  mem_rsp_valid, mem_rsp_tag, m_axi_bready, m_axi_rready);
      else n_pass++;
      tick();
      m_axi_bvalid = 1'b0;
      n_total++;
      if (busy !== 1'b0) $display("FAIL prio_busy_done: got %b, required 0", busy);
      else n_pass++;
   endtask

   task automatic test_err();
      logic [511:0] ed = {8{64'hEEEE_0000_0000_000B}};
      m_axi_arready = 1'b1;
      do_req(1'b0, 26'hB, 8'h0B, '0);
      expect_rsp(8'h0B, ed);
      send_r(8'h0B, ed, 2'b10);
      m_axi_arready = 1'b0;
      n_total++;
      if (axi_err !== 1'b1) $display("FAIL err_set: got %b, required 1", axi_err);
      else n_pass++;
      repeat (3) tick();
      n_total++;
      if (axi_err !== 1'b1 || busy !== 1'b0)
         $display("FAIL err_sticky: err %b busy %b, required 1 0", axi_err, busy);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (axi_err !== 1'b0 || busy !== 1'b0)
         $display("FAIL err_reset: err %b busy %b, required 0 0", axi_err, busy);
      else n_pass++;
      tick();
      reset = 1'b1;
      tick();
      n_total++;
      if (axi_err !== 1'b0) $display("FAIL err_after_reset: got %b, required 0", axi_err);
      else n_pass++;
   endtask

   task automatic test_reset_inflight();
      m_axi_arready = 1'b1;
      do_req(1'b0, 26'h20, 8'h20, '0);
      do_req(1'b0, 26'h21, 8'h21, '0);
      m_axi_arready = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      do_req(1'b1, 26'h22, 8'h22, {16{32'h2222_2222}});
      n_total++;
      if (busy !== 1'b1 || dut.rd_cnt_q !== 2'd2 || dut.wr_cnt_q !== 2'd1 || m_axi_awvalid !== 1'b1)
         $display("FAIL inflight_setup: busy %b rd %0d wr %0d aw %b, required 1 2 1 1",
                  busy, dut.rd_cnt_q, dut.wr_cnt_q, m_axi_awvalid);
      else n_pass++;
      #2;
      reset         = 1'b0;
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      #1;
      n_total += 3;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b000 || busy !== 1'b0)
         $display("FAIL inflight_valids: valids %b busy %b, required 000 0",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, busy);
      else n_pass++;
      if (dut.rd_cnt_q !== 2'd0 || dut.wr_cnt_q !== 2'd0)
         $display("FAIL inflight_counts: rd %0d wr %0d, required 0 0", dut.rd_cnt_q, dut.wr_cnt_q);
      else n_pass++;
      if (mem_req_ready !== 1'b0 || m_axi_awaddr !== 32'h0 || m_axi_wdata !== 512'h0)
         $display("FAIL inflight_regs: ready %b awaddr %h, required 0 0", mem_req_ready, m_axi_awaddr);
      else n_pass++;
      mem_req_valid = 1'b0;
      exp_q.delete();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_resume();
      logic [511:0] d = {8{64'h1313_1313_1313_1313}};
      m_axi_arready = 1'b0;
      do_req(1'b0, 26'h3FF_FFFF, 8'h13, '0);
      expect_rsp(8'h13, d);
      n_total++;
      if (m_axi_araddr !== 32'hFFFF_FFC0 || m_axi_arid !== 8'h13)
         $display("FAIL resume_ar: addr %h id %h, required ffffffc0 13", m_axi_araddr, m_axi_arid);
      else n_pass++;
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      send_r(8'h13, d, 2'b00);
      n_total++;
      if (busy !== 1'b0 || axi_err !== 1'b0)
         $display("FAIL resume_done: busy %b err %b, required 0 0", busy, axi_err);
      else n_pass++;
   endtask

   initial begin
      reset          = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_rw     = 1'b0;
      mem_req_byteen = '1;
      mem_req_addr   = '0;
      mem_req_data   = '0;
      mem_req_tag    = '0;
      mem_rsp_ready  = 1'b1;
      m_axi_awready  = 1'b0;
      m_axi_wready   = 1'b0;
      m_axi_arready  = 1'b0;
      m_axi_bvalid   = 1'b0;
      m_axi_bid      = '0;
      m_axi_bresp    = 2'b00;
      m_axi_rvalid   = 1'b0;
      m_axi_rid      = '0;
      m_axi_rdata    = '0;
      m_axi_rresp    = 2'b00;
      m_axi_rlast    = 1'b1;

      test_reset();
      test_read();
      test_max_rd();
      test_write();
      test_rb_priority();
      test_err();
      test_reset_inflight();
      test_resume();

      repeat (2) tick();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
      else n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
